// File: rtl/plp_bus_pkg.sv
// Shared types and constants for the PLP data-bus arbiter family.
package plp_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    localparam logic [1:0] DRW_WRITE = 2'b01;
    localparam logic [1:0] DRW_READ  = 2'b10;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/plp_arb_pick.sv
// Two-way winner select: a lone requester wins; a tie goes to m0 under fixed
// priority, otherwise to whichever master was not served last.
module plp_arb_pick
    import plp_bus_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o
);

    always_comb begin
        winner_o = M0;
        case (req_i)
            2'b10:   winner_o = M1;
            2'b11:   winner_o = FIXED_PRIO ? M0 : ~last_i;
            default: winner_o = M0;
        endcase
    end

endmodule

// File: rtl/plp_dbus_arbiter.sv
// Shares one PLP peripheral data port between two masters with a
// request/grant/ack handshake; the slave read data is registered for the ack.
module plp_dbus_arbiter
    import plp_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_rw,
    input  logic [31:0] m0_din,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [31:0] m0_dout,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_rw,
    input  logic [31:0] m1_din,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] m1_dout,
    output logic        s_de,
    output logic [31:0] s_daddr,
    output logic [1:0]  s_drw,
    output logic [31:0] s_din,
    input  logic [31:0] s_dout
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e      state_q;
    logic        owner_q;
    logic        last_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        winner;
    logic        in_access;
    logic        in_ack;

    plp_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req_i   ({m1_req, m0_req}),
        .last_i  (last_q),
        .winner_o(winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= M0;
            last_q  <= M1;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner_q <= winner;
                        cnt_q   <= WS;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q <= s_dout;
                        last_q  <= owner_q;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                // No arbitration here, so a held req from the owner waits for IDLE.
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_ack    = (state_q == ACK);

    assign m0_gnt  = in_access && (owner_q == M0);
    assign m1_gnt  = in_access && (owner_q == M1);
    assign m0_ack  = in_ack && (owner_q == M0);
    assign m1_ack  = in_ack && (owner_q == M1);
    assign m0_dout = m0_ack ? rdata_q : '0;
    assign m1_dout = m1_ack ? rdata_q : '0;

    // Slave side follows the owner's live inputs during ACCESS, idles at zero otherwise.
    assign s_de    = in_access;
    assign s_daddr = in_access ? ((owner_q == M1) ? m1_addr : m0_addr) : '0;
    assign s_drw   = in_access ? ((owner_q == M1) ? m1_rw   : m0_rw)   : '0;
    assign s_din   = in_access ? ((owner_q == M1) ? m1_din  : m0_din)  : '0;

endmodule
